// File: rtl/alu_dispatch_pkg.sv
// Shared op codes, alu function codes and instruction field positions for the alu issue stage.
package alu_dispatch_pkg;

    localparam int OP_MSB = 15;
    localparam int RD_LSB = 10;
    localparam int RS_LSB = 7;
    localparam int RT_LSB = 4;
    localparam int IMM_W  = 7;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3
    } alu_func_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_ANDI = 3'd5;

    // Immediate forms reuse the arithmetic/logic function of their register form.
    function automatic logic [2:0] op_to_func(input logic [2:0] op);
        case (op)
            OP_SUB:          op_to_func = FN_SUB;
            OP_AND, OP_ANDI: op_to_func = FN_AND;
            OP_OR:           op_to_func = FN_OR;
            default:         op_to_func = FN_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_dispatch_tag_fifo2.sv
// Two-entry FIFO of destination tags; slot 0 is always the head, and both
// slots expose a match against two compare tags for hazard detection.
module alu_dispatch_tag_fifo2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [2:0] din,
    input  logic [2:0] cmp_a,
    input  logic [2:0] cmp_b,
    output logic [2:0] head,
    output logic       full,
    output logic       empty,
    output logic [1:0] match_a,
    output logic [1:0] match_b
);

    logic [2:0] slot_q [2];
    logic [2:0] slot_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && (do_pop || (cnt_q != 2'd2));
        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot_d[0] = din;
                else               slot_d[1] = din;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot_d[0] = slot_q[1];
                cnt_d     = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot_d[0] = din;
                end else begin
                    slot_d[0] = slot_q[1];
                    slot_d[1] = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= 3'd0;
            slot_q[1] <= 3'd0;
            cnt_q     <= 2'd0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head       = slot_q[0];
    assign full       = (cnt_q == 2'd2);
    assign empty      = (cnt_q == 2'd0);
    assign match_a[0] = (cnt_q != 2'd0) && (slot_q[0] == cmp_a);
    assign match_a[1] = (cnt_q == 2'd2) && (slot_q[1] == cmp_a);
    assign match_b[0] = (cnt_q != 2'd0) && (slot_q[0] == cmp_b);
    assign match_b[1] = (cnt_q == 2'd2) && (slot_q[1] == cmp_b);

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage for the alu: decodes instructions, reads the 8-entry register file,
// drives one-cycle issue strobes and writes returning results back in order.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [2:0]        alu_func,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    output logic              en_in,
    input  logic [DWIDTH-1:0] alu_out,
    input  logic              en_out,
    input  logic [2:0]        dbg_addr,
    output logic [DWIDTH-1:0] dbg_data,
    output logic              busy,
    output logic              wb_err
);

    logic [DWIDTH-1:0] regs_q [8];
    logic [DWIDTH-1:0] regs_d [8];
    logic [2:0]        alu_func_q, alu_func_d;
    logic [DWIDTH-1:0] alu_a_q, alu_a_d;
    logic [DWIDTH-1:0] alu_b_q, alu_b_d;
    logic              en_in_q, en_in_d;
    logic              wb_err_q, wb_err_d;

    logic [2:0]        op, rd, rs, rt;
    logic [IMM_W-1:0]  imm;
    logic              is_rtype, is_valid_op;
    logic [DWIDTH-1:0] rd_a, rd_b;
    logic              accept, push, pop, hazard;
    logic [2:0]        head;
    logic              full, empty;
    logic [1:0]        match_rs, match_rt;

    assign op  = instr[OP_MSB -: 3];
    assign rd  = instr[RD_LSB +: 3];
    assign rs  = instr[RS_LSB +: 3];
    assign rt  = instr[RT_LSB +: 3];
    assign imm = instr[IMM_W-1:0];

    assign is_rtype    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign is_valid_op = is_rtype || (op == OP_ADDI) || (op == OP_ANDI);

    assign rd_a = (rs == 3'd0) ? '0 : regs_q[rs];
    assign rd_b = (rt == 3'd0) ? '0 : regs_q[rt];

    // Matches use the queue contents before this edge's pop, so a source being
    // written back this cycle still stalls and is read after the write lands.
    assign hazard = ((rs != 3'd0) && (|match_rs))
                 || (is_rtype && (rt != 3'd0) && (|match_rt));

    assign pop         = en_out && !empty;
    assign instr_ready = !(full && !pop) && !(instr_valid && hazard);
    assign accept      = instr_valid && instr_ready;
    assign push        = accept && is_valid_op;

    alu_dispatch_tag_fifo2 u_tags (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (rd),
        .cmp_a   (rs),
        .cmp_b   (rt),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .match_a (match_rs),
        .match_b (match_rt)
    );

    always_comb begin
        regs_d     = regs_q;
        alu_func_d = alu_func_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        en_in_d    = push;
        wb_err_d   = wb_err_q || (en_out && empty);
        if (pop && (head != 3'd0)) begin
            regs_d[head] = alu_out;
        end
        if (push) begin
            alu_func_d = op_to_func(op);
            alu_a_d    = rd_a;
            if (is_rtype)            alu_b_d = rd_b;
            else if (op == OP_ADDI)  alu_b_d = {{(DWIDTH-IMM_W){imm[IMM_W-1]}}, imm};
            else                     alu_b_d = {{(DWIDTH-IMM_W){1'b0}}, imm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            alu_func_q <= 3'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            en_in_q    <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            alu_func_q <= alu_func_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            en_in_q    <= en_in_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign alu_func = alu_func_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign en_in    = en_in_q;
    assign wb_err   = wb_err_q;
    assign busy     = !empty;
    assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural one-cycle alu attached.
module tb_alu_dispatch;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_func;
    logic [15:0] alu_a, alu_b;
    logic        en_in;
    logic [15:0] alu_out;
    logic        en_out;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        busy;
    logic        wb_err;

    logic        alu_en_q;
    logic [15:0] alu_res_q;
    logic        force_en;
    logic [15:0] force_val;

    int n_checks;
    int n_fail;

    alu_dispatch #(.DWIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_func    (alu_func),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .en_in       (en_in),
        .alu_out     (alu_out),
        .en_out      (en_out),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .wb_err      (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural alu: latches on the edge after en_in, result valid one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en_q  <= 1'b0;
            alu_res_q <= 16'h0;
        end else begin
            alu_en_q <= en_in;
            if (en_in) begin
                case (alu_func)
                    3'd0:    alu_res_q <= alu_a + alu_b;
                    3'd1:    alu_res_q <= alu_a - alu_b;
                    3'd2:    alu_res_q <= alu_a & alu_b;
                    3'd3:    alu_res_q <= alu_a | alu_b;
                    default: alu_res_q <= 16'h0;
                endcase
            end
        end
    end

    assign en_out  = alu_en_q | force_en;
    assign alu_out = force_en ? force_val : alu_res_q;

    function automatic logic [15:0] rtype(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        rtype = {op, rd, rs, rt, 4'b0000};
    endfunction

    function automatic logic [15:0] itype(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [6:0] imm);
        itype = {op, rd, rs, imm};
    endfunction

    // Presents one instruction, returns after the accept edge (+1) with the stall count.
    task automatic send(input logic [15:0] w, output int stalls);
        int guard;
        stalls      = 0;
        guard       = 0;
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && guard < 20) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: instr_ready stayed %0b for instr %h, required 1", instr_ready, w);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b, required 0", busy);
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        n_checks++;
        if ({alu_func, alu_a, alu_b, en_in, busy, wb_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: func=%h a=%h b=%h en_in=%b busy=%b wb_err=%b, required all 0",
                     alu_func, alu_a, alu_b, en_in, busy, wb_err);
        end
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: instr_ready=%b, required 1", instr_ready);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            n_checks++;
            if (v !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_dbg_r%0d: got %h, required 0000", i, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        logic [15:0] v;
        send(itype(3'd4, 3'd1, 3'd0, 7'd5), s1);
        n_checks++;
        if (en_in !== 1'b1 || alu_b !== 16'h0005) begin
            n_fail++;
            $display("FAIL b2b_issue1: en_in=%b alu_b=%h, required 1 0005", en_in, alu_b);
        end
        send(itype(3'd4, 3'd2, 3'd0, 7'h7D), s2);
        n_checks++;
        if (en_in !== 1'b1 || alu_b !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL b2b_issue2: en_in=%b alu_b=%h, required 1 fffd", en_in, alu_b);
        end
        n_checks++;
        if (s1 != 0 || s2 != 0) begin
            n_fail++;
            $display("FAIL b2b_stall: stalls %0d/%0d, required 0/0", s1, s2);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (en_in !== 1'b0 || alu_b !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL b2b_strobe_drop: en_in=%b alu_b=%h, required 0 fffd (held)", en_in, alu_b);
        end
        wait_idle();
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h0005) begin
            n_fail++;
            $display("FAIL b2b_r1: got %h, required 0005", v);
        end
        read_reg(3'd2, v);
        n_checks++;
        if (v !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL b2b_r2: got %h, required fffd", v);
        end
    endtask

    task automatic test_raw_stall();
        int s;
        logic [15:0] v;
        send(itype(3'd4, 3'd1, 3'd0, 7'd5), s);
        send(itype(3'd4, 3'd2, 3'd0, 7'h7D), s);
        send(rtype(3'd0, 3'd3, 3'd1, 3'd2), s);
        n_checks++;
        if (s != 2) begin
            n_fail++;
            $display("FAIL raw_stall_cycles: got %0d, required 2", s);
        end
        n_checks++;
        if (en_in !== 1'b1 || alu_a !== 16'h0005 || alu_b !== 16'hFFFD || alu_func !== 3'd0) begin
            n_fail++;
            $display("FAIL raw_operands: en_in=%b a=%h b=%h func=%h, required 1 0005 fffd 0",
                     en_in, alu_a, alu_b, alu_func);
        end
        wait_idle();
        read_reg(3'd3, v);
        n_checks++;
        if (v !== 16'h0002) begin
            n_fail++;
            $display("FAIL raw_r3: got %h, required 0002", v);
        end
    endtask

    task automatic test_logic_ops();
        int s;
        logic [15:0] v;
        send(itype(3'd5, 3'd4, 3'd2, 7'h7F), s);
        n_checks++;
        if (alu_a !== 16'hFFFD || alu_b !== 16'h007F || alu_func !== 3'd2) begin
            n_fail++;
            $display("FAIL andi_operands: a=%h b=%h func=%h, required fffd 007f 2", alu_a, alu_b, alu_func);
        end
        send(rtype(3'd1, 3'd5, 3'd1, 3'd2), s);
        n_checks++;
        if (s != 0 || alu_func !== 3'd1) begin
            n_fail++;
            $display("FAIL sub_issue: stalls=%0d func=%h, required 0 1", s, alu_func);
        end
        send(rtype(3'd3, 3'd6, 3'd1, 3'd4), s);
        n_checks++;
        if (s != 1 || alu_a !== 16'h0005 || alu_b !== 16'h007D) begin
            n_fail++;
            $display("FAIL or_hazard: stalls=%0d a=%h b=%h, required 1 0005 007d", s, alu_a, alu_b);
        end
        wait_idle();
        read_reg(3'd4, v);
        n_checks++;
        if (v !== 16'h007D) begin
            n_fail++;
            $display("FAIL andi_r4: got %h, required 007d", v);
        end
        read_reg(3'd5, v);
        n_checks++;
        if (v !== 16'h0008) begin
            n_fail++;
            $display("FAIL sub_r5: got %h, required 0008", v);
        end
        read_reg(3'd6, v);
        n_checks++;
        if (v !== 16'h007D) begin
            n_fail++;
            $display("FAIL or_r6: got %h, required 007d", v);
        end
    endtask

    task automatic test_r0_and_nop();
        int s1, s2;
        logic [15:0] v;
        send(itype(3'd4, 3'd0, 3'd0, 7'd9), s1);
        send(rtype(3'd0, 3'd7, 3'd0, 3'd0), s2);
        n_checks++;
        if (s1 != 0 || s2 != 0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            n_fail++;
            $display("FAIL r0_no_stall: stalls %0d/%0d a=%h b=%h, required 0/0 0000 0000", s1, s2, alu_a, alu_b);
        end
        wait_idle();
        read_reg(3'd0, v);
        n_checks++;
        if (v !== 16'h0) begin
            n_fail++;
            $display("FAIL r0_reads_zero: got %h, required 0000", v);
        end
        read_reg(3'd7, v);
        n_checks++;
        if (v !== 16'h0) begin
            n_fail++;
            $display("FAIL r7_zero: got %h, required 0000", v);
        end
        send(16'hDFFF, s1);
        n_checks++;
        if (s1 != 0 || en_in !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_op: stalls=%0d en_in=%b busy=%b, required 0 0 0", s1, en_in, busy);
        end
        @(posedge clk);
        #1;
        read_reg(3'd1, v);
        n_checks++;
        if (busy !== 1'b0 || en_in !== 1'b0 || v !== 16'h0005) begin
            n_fail++;
            $display("FAIL nop_after: busy=%b en_in=%b r1=%h, required 0 0 0005", busy, en_in, v);
        end
    endtask

    task automatic test_reset_midflight();
        int s;
        logic [15:0] v;
        send(itype(3'd4, 3'd1, 3'd0, 7'd1), s);
        send(itype(3'd4, 3'd2, 3'd0, 7'd2), s);
        rst_n = 1'b0;
        #1;
        read_reg(3'd1, v);
        n_checks++;
        if (busy !== 1'b0 || en_in !== 1'b0 || alu_a !== 16'h0 || alu_b !== 16'h0 || v !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b en_in=%b a=%h b=%h r1=%h, required 0 0 0000 0000 0000",
                     busy, en_in, alu_a, alu_b, v);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 1; i < 8; i++) begin
            read_reg(3'(i), v);
            n_checks++;
            if (v !== 16'h0) begin
                n_fail++;
                $display("FAIL post_reset_r%0d: got %h, required 0000", i, v);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_flags: busy=%b wb_err=%b, required 0 0", busy, wb_err);
        end
        force_val = 16'hABCD;
        force_en  = 1'b1;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        n_checks++;
        if (wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_err_set: got %b, required 1", wb_err);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            n_checks++;
            if (v !== 16'h0) begin
                n_fail++;
                $display("FAIL stray_write_r%0d: got %h, required 0000", i, v);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wb_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_err_sticky: wb_err=%b busy=%b, required 1 0", wb_err, busy);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_addr    = 3'd0;
        force_en    = 1'b0;
        force_val   = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_logic_ops();
        test_r0_and_nop();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
